// File: rtl/tipi_pkg.sv
// rtl/tipi_pkg.sv - shared FSM states, channel ids and shift width; TIPI_SHIFT_PARITY_EN adds an odd-parity bit
package tipi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    LATCH_LO,
    LATCH_HI
  } tipi_state_t;

  localparam logic CH_CONTROL = 1'b0;
  localparam logic CH_DATA    = 1'b1;

`ifdef TIPI_SHIFT_PARITY_EN
  localparam int SHIFT_BITS = 9;
`else
  localparam int SHIFT_BITS = 8;
`endif

  // Word as it leaves the shifter, MSB first; parity (when enabled) trails bit 0.
  function automatic logic [SHIFT_BITS-1:0] shift_word(input logic [7:0] b);
`ifdef TIPI_SHIFT_PARITY_EN
    return {b, ~^b};
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/tipi_serial_ctrl_if.sv
// rtl/tipi_serial_ctrl_if.sv - TI-side byte writes and RPi-side serial link bundled for tipi_serial_ctrl
interface tipi_serial_ctrl_if;
  logic       tc_wr;
  logic [7:0] tc_byte;
  logic       td_wr;
  logic [7:0] td_byte;
  logic       rpi_busy;
  logic       ovr_clr;
  logic       rpi_sclk;
  logic       rpi_sdo;
  logic       rpi_sel;
  logic       rpi_le;
  logic       tc_pending;
  logic       td_pending;
  logic       tc_ovr;
  logic       td_ovr;
  logic       done;
  logic       done_sel;

  modport master (
    output tc_wr, tc_byte, td_wr, td_byte, rpi_busy, ovr_clr,
    input  rpi_sclk, rpi_sdo, rpi_sel, rpi_le,
    input  tc_pending, td_pending, tc_ovr, td_ovr, done, done_sel
  );

  modport slave (
    input  tc_wr, tc_byte, td_wr, td_byte, rpi_busy, ovr_clr,
    output rpi_sclk, rpi_sdo, rpi_sel, rpi_le,
    output tc_pending, td_pending, tc_ovr, td_ovr, done, done_sel
  );
endinterface

// File: rtl/tipi_clkdiv.sv
// rtl/tipi_clkdiv.sv - half-period counter; tc pulses on the last clk of each CLK_DIV-cycle phase
module tipi_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  logic [7:0] cnt;

  assign tc = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (restart || tc)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/tipi_serial_ctrl.sv
// rtl/tipi_serial_ctrl.sv - shifts TI control/data bytes to the RPi over sclk/sdo/sel/le
// Optional TIPI_SHIFT_PARITY_EN appends an odd-parity bit to every shifted byte.
module tipi_serial_ctrl
  import tipi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  tipi_serial_ctrl_if.slave bus
);

  tipi_state_t           state;
  logic [7:0]            tc_shadow, td_shadow;
  logic                  tc_pend, td_pend;
  logic                  tc_ovr_r, td_ovr_r;
  logic                  last_ch;
  logic [SHIFT_BITS-1:0] sh;
  logic [3:0]            bits_left;
  logic                  sclk, sel, le, done, done_sel;
  logic                  half_tc;
  logic                  pick, start, tc_take, td_take;
  logic [SHIFT_BITS-1:0] load_word;

  // Counter is held clear while idle so SETUP always gets a full half-period.
  tipi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .tc      (half_tc)
  );

  always_comb begin
    pick = CH_CONTROL;
    if (td_pend && (!tc_pend || last_ch == CH_CONTROL))
      pick = CH_DATA;
  end

  assign start     = (state == IDLE) && !bus.rpi_busy && (tc_pend || td_pend);
  assign tc_take   = start && (pick == CH_CONTROL);
  assign td_take   = start && (pick == CH_DATA);
  assign load_word = shift_word((pick == CH_DATA) ? td_shadow : tc_shadow);

  // A write landing on the cycle its channel is taken is a fresh byte, not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_shadow <= '0;
      td_shadow <= '0;
      tc_pend   <= 1'b0;
      td_pend   <= 1'b0;
      tc_ovr_r  <= 1'b0;
      td_ovr_r  <= 1'b0;
    end else begin
      if (bus.tc_wr) tc_shadow <= bus.tc_byte;
      if (bus.td_wr) td_shadow <= bus.td_byte;
      tc_pend  <= bus.tc_wr || (tc_pend && !tc_take);
      td_pend  <= bus.td_wr || (td_pend && !td_take);
      tc_ovr_r <= (bus.tc_wr && tc_pend && !tc_take) || (tc_ovr_r && !bus.ovr_clr);
      td_ovr_r <= (bus.td_wr && td_pend && !td_take) || (td_ovr_r && !bus.ovr_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      bits_left <= '0;
      sclk      <= 1'b0;
      sel       <= 1'b0;
      le        <= 1'b0;
      done      <= 1'b0;
      done_sel  <= 1'b0;
      last_ch   <= CH_DATA;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh        <= load_word;
          sel       <= pick;
          last_ch   <= pick;
          bits_left <= 4'(SHIFT_BITS - 1);
          sclk      <= 1'b0;
          state     <= SETUP;
        end
        SETUP: if (half_tc) begin
          sclk  <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (half_tc) begin
          sclk <= 1'b0;
          if (bits_left != 4'd0) begin
            sh        <= {sh[SHIFT_BITS-2:0], 1'b0};
            bits_left <= bits_left - 4'd1;
            state     <= LOW;
          end else begin
            le    <= 1'b1;
            state <= LATCH_LO;
          end
        end
        LOW: if (half_tc) begin
          sclk  <= 1'b1;
          state <= HIGH;
        end
        LATCH_LO: if (half_tc) begin
          sclk  <= 1'b1;
          state <= LATCH_HI;
        end
        LATCH_HI: if (half_tc) begin
          sclk     <= 1'b0;
          le       <= 1'b0;
          sh       <= '0;
          done     <= 1'b1;
          done_sel <= sel;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rpi_sclk   = sclk;
  assign bus.rpi_sdo    = sh[SHIFT_BITS-1];
  assign bus.rpi_sel    = sel;
  assign bus.rpi_le     = le;
  assign bus.tc_pending = tc_pend;
  assign bus.td_pending = td_pend;
  assign bus.tc_ovr     = tc_ovr_r;
  assign bus.td_ovr     = td_ovr_r;
  assign bus.done       = done;
  assign bus.done_sel   = done_sel;

endmodule

// File: doc/tipi_serial_ctrl.md
TIPI_SERIAL_CTRL -- requirements
Module: tipi_serial_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per serial half-period (legal 1..255).
REQ-002 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port tc_wr, input, 1, clk-domain pulse: new TI control byte available.
REQ-005 SHALL have port tc_byte, input, 8, TI control byte, sampled when tc_wr=1.
REQ-006 SHALL have port td_wr, input, 1, clk-domain pulse: new TI data byte available.
REQ-007 SHALL have port td_byte, input, 8, TI data byte, sampled when td_wr=1.
REQ-008 SHALL have port rpi_busy, input, 1, RPi not ready; blocks transfer start only.
REQ-009 SHALL have port ovr_clr, input, 1, clears overrun flags.
REQ-010 SHALL have port rpi_sclk, output, 1, serial clock to RPi.
REQ-011 SHALL have port rpi_sdo, output, 1, serial data, MSB first.
REQ-012 SHALL have port rpi_sel, output, 1, channel select: 0 control, 1 data.
REQ-013 SHALL have port rpi_le, output, 1, latch enable to RPi.
REQ-014 SHALL have ports tc_pending, td_pending, output, 1 each, byte waiting for transfer.
REQ-015 SHALL have ports tc_ovr, td_ovr, output, 1 each, sticky overrun flags.
REQ-016 SHALL have ports done, output, 1, one-cycle pulse at transfer end; done_sel, output, 1, channel of that transfer.

Function
- REQ-017 SHALL capture tc_byte/td_byte into per-channel shadow registers on tc_wr/td_wr and set the matching pending flag the next cycle.
- REQ-018 SHALL, on a write while that channel is already pending, overwrite the shadow and set its ovr flag; writes during that channel's active shift are not overruns.
- REQ-019 SHALL implement states IDLE, SETUP, HIGH, LOW, LATCH_LO, LATCH_HI.
- REQ-020 IDLE: when rpi_busy=0 and any pending, SHALL load the shift register from the chosen shadow, clear that pending flag, go SETUP.
- REQ-021 Arbitration: control wins when both pending, except data wins if the previous transfer was control (alternating when both pending).
- REQ-022 SETUP: sclk=0, sel driven, sdo=bit 7, for CLK_DIV cycles, then HIGH.
- REQ-023 HIGH: sclk=1 for CLK_DIV cycles; then LOW if bits remain, else LATCH_LO.
- REQ-024 LOW: sclk=0, sdo=next bit from cycle of entry, for CLK_DIV cycles, then HIGH.
- REQ-025 LATCH_LO: le=1, sclk=0 for CLK_DIV; LATCH_HI: le=1, sclk=1 for CLK_DIV; then IDLE with done=1 for one cycle.
- REQ-026 Transfer length SHALL be 18*CLK_DIV cycles from leaving IDLE to re-entering IDLE (20*CLK_DIV with parity).
- REQ-027 rpi_sel and rpi_sdo SHALL be stable while sclk=1; rpi_busy changes mid-transfer SHALL be ignored.
- REQ-028 ovr_clr SHALL clear both ovr flags; simultaneous new overrun event SHALL win (flag stays set).
- REQ-029 Same-cycle tc_wr and td_wr SHALL both be captured.

Reset
- REQ-030 rst SHALL force IDLE, sclk=0, sdo=0, sel=0, le=0, done=0, done_sel=0, pending=0, ovr=0, shadows=0, arbitration history=data.
- REQ-031 rst asserted mid-transfer SHALL abort immediately with le never asserted; the byte is lost.

Configuration
- REQ-032 With TIPI_SHIFT_PARITY_EN defined, SHALL append an odd-parity bit after bit 0 (9 bits shifted). Without it, exactly 8 bits SHALL be shifted.

Structure
- REQ-033 State encoding, CH_CONTROL/CH_DATA constants, and the bit-count constant SHALL live in shared package tipi_pkg.
- REQ-034 The half-period counter SHALL be sub-module tipi_clkdiv (terminal-count pulse, restart on state change); shifter/FSM stay in top.

Verification
- REQ-035 CLK_DIV=2, tc_wr with 0xA5, rpi_busy=0 -> sel=0, sdo bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges, le high over the final sclk pulse, done at cycle 36.
- REQ-036 tc_wr 0x11 and td_wr 0x22 in same cycle -> control 0x11 shifted first, then data 0x22, two done pulses, done_sel 0 then 1.
- REQ-037 rpi_busy=1, td_wr 0x33 then td_wr 0x44 -> td_pending=1, td_ovr=1; release busy -> only 0x44 shifted; ovr_clr -> td_ovr=0.
- REQ-038 rst pulse at cycle 10 of a transfer -> all outputs at reset values next cycle, le never high, no done.
- REQ-039 TIPI_SHIFT_PARITY_EN, byte 0x07 -> 9 bits, parity bit 0, done at cycle 40 (CLK_DIV=2).
- REQ-040 td_wr 0x55 during an active data transfer of 0x66 -> 0x66 completes, td_ovr=0, 0x55 shifted next.
